// File: rtl/let_dtm.sv
// rtl/let_dtm.sv - JTAG debug transport module bridging a 5-bit-IR TAP to a DMI bus
module let_dtm #(
    parameter int unsigned ABITS      = 7,
    parameter int unsigned IDLE       = 1,
    parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    output logic [31:0]      select_val,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [1:0]       dmi_req_op,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_wdata,
    input  logic             dmi_resp_valid,
    input  logic [31:0]      dmi_resp_rdata,
    input  logic             dmi_resp_err
);
    localparam int unsigned DRW = ABITS + 34;
    localparam int unsigned CW  = $clog2(DRW + 1);

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_BTXCS  = 5'h10;
    localparam logic [4:0] IR_BTX    = 5'h11;
    localparam logic [4:0] IR_SELECT = 5'h12;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_e;

    typedef enum logic [1:0] {DMI_IDLE, DMI_REQ, DMI_WAIT} dmi_e;

    tap_e           tap_q, tap_d;
    dmi_e           dmi_q, dmi_d;
    logic [4:0]     ir_q, ir_sh_q;
    logic [DRW-1:0] dr_in_q, dr_out_q, cap_img;
    logic [CW-1:0]  cnt_q;
    logic [31:0]    select_q, rdata_q, rdata_d;
    logic [1:0]     status_q, status_d;
    logic [1:0]     op_q;
    logic [ABITS-1:0] addr_q;
    logic [31:0]    wdata_q;
    logic           btx_go, start;

    always_ff @(posedge clk) begin
        if (rst) tap_q <= TLR;
        else     tap_q <= tap_d;
    end

    always_comb begin
        tap_d = tap_q;
        case (tap_q)
            TLR:      tap_d = tms ? TLR      : RTI;
            RTI:      tap_d = tms ? SEL_DR   : RTI;
            SEL_DR:   tap_d = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   tap_d = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: tap_d = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: tap_d = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: tap_d = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: tap_d = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   tap_d = tms ? SEL_DR   : RTI;
            SEL_IR:   tap_d = tms ? TLR      : CAP_IR;
            CAP_IR:   tap_d = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: tap_d = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: tap_d = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: tap_d = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: tap_d = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   tap_d = tms ? SEL_DR   : RTI;
            default:  tap_d = TLR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q    <= IR_IDCODE;
            ir_sh_q <= '0;
        end else begin
            case (tap_q)
                TLR:      ir_q    <= IR_IDCODE;
                CAP_IR:   ir_sh_q <= 5'b00001;
                SHIFT_IR: ir_sh_q <= {tdi, ir_sh_q[4:1]};
                UPD_IR:   ir_q    <= ir_sh_q;
                default:  ;
            endcase
        end
    end

    // Unlisted instruction codes fall through to an all-zero image, i.e. bypass.
    always_comb begin
        cap_img = '0;
        case (ir_q)
            IR_IDCODE: cap_img[31:0] = IDCODE_VAL;
            IR_BTXCS:  cap_img[14:0] = {3'(IDLE), status_q, 6'(ABITS), 4'd1};
            IR_BTX:    cap_img[33:0] = {rdata_q, status_q};
            IR_SELECT: cap_img[31:0] = select_q;
            default:   ;
        endcase
    end

    // DR bits are addressed by a counter so short shifts leave the tail at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            dr_in_q  <= '0;
            dr_out_q <= '0;
            cnt_q    <= '0;
            select_q <= '0;
        end else begin
            case (tap_q)
                CAP_DR: begin
                    dr_in_q  <= '0;
                    dr_out_q <= cap_img;
                    cnt_q    <= '0;
                end
                SHIFT_DR: begin
                    if (cnt_q < CW'(DRW)) begin
                        dr_in_q[cnt_q] <= tdi;
                        cnt_q          <= cnt_q + 1'b1;
                    end
                end
                UPD_DR: if (ir_q == IR_SELECT) select_q <= dr_in_q[31:0];
                default: ;
            endcase
        end
    end

    assign tdo = (tap_q == SHIFT_DR && cnt_q < CW'(DRW)) ? dr_out_q[cnt_q] : 1'b0;

    assign btx_go = (tap_q == UPD_DR) && (ir_q == IR_BTX) &&
                    (dr_in_q[1:0] == 2'd1 || dr_in_q[1:0] == 2'd2);

    // A response landing on the same edge as an update retires first, freeing the slot.
    always_comb begin
        dmi_d    = dmi_q;
        status_d = status_q;
        rdata_d  = rdata_q;
        start    = 1'b0;
        case (dmi_q)
            DMI_REQ:  if (dmi_req_ready) dmi_d = DMI_WAIT;
            DMI_WAIT: begin
                if (dmi_resp_valid) begin
                    dmi_d    = DMI_IDLE;
                    status_d = dmi_resp_err ? 2'd2 : 2'd0;
                    if (op_q == 2'd1) rdata_d = dmi_resp_rdata;
                end
            end
            default: ;
        endcase
        if (btx_go && dmi_d == DMI_IDLE) begin
            start    = 1'b1;
            dmi_d    = DMI_REQ;
            status_d = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmi_q    <= DMI_IDLE;
            status_q <= '0;
            rdata_q  <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            dmi_q    <= dmi_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
            if (start) begin
                op_q    <= dr_in_q[1:0];
                addr_q  <= dr_in_q[ABITS+1:2];
                wdata_q <= dr_in_q[ABITS+33:ABITS+2];
            end
        end
    end

    assign dmi_req_valid = (dmi_q == DMI_REQ) && !rst;
    assign dmi_req_op    = op_q;
    assign dmi_req_addr  = addr_q;
    assign dmi_req_wdata = wdata_q;
    assign select_val    = select_q;

endmodule

// File: tb/tb_let_dtm.sv
// tb/tb_let_dtm.sv - randomized self-checking bench for let_dtm against a transaction-level model
module tb_let_dtm;
    localparam int          ABITS  = 7;
    localparam logic [31:0] IDCODE = 32'h0000_0001;

    logic             clk = 1'b0;
    logic             rst, tms, tdi, tdo;
    logic [31:0]      select_val;
    logic             dmi_req_valid, dmi_req_ready;
    logic [1:0]       dmi_req_op;
    logic [ABITS-1:0] dmi_req_addr;
    logic [31:0]      dmi_req_wdata;
    logic             dmi_resp_valid;
    logic [31:0]      dmi_resp_rdata;
    logic             dmi_resp_err;

    int checks = 0;
    int errors = 0;

    int          ready_dly = 0, resp_dly = 0;
    bit          resp_hold = 0, ready_block = 0;
    logic [31:0] nxt_rdata = 32'd0;
    logic        nxt_err = 1'b0;
    int          req_cnt = 0, resp_cnt = 0;
    logic [1:0]  got_op;
    logic [6:0]  got_addr;
    logic [31:0] got_wdata;

    logic [1:0]  m_status = 2'd0;
    logic [31:0] m_rdata = 32'd0;
    bit          m_busy = 0;
    logic [1:0]  e_op;
    logic [6:0]  e_addr;
    logic [31:0] e_wdata;
    int          e_req = 0;

    let_dtm #(.ABITS(ABITS), .IDLE(1), .IDCODE_VAL(IDCODE)) dut (
        .clk(clk), .rst(rst), .tms(tms), .tdi(tdi), .tdo(tdo), .select_val(select_val),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_op(dmi_req_op), .dmi_req_addr(dmi_req_addr), .dmi_req_wdata(dmi_req_wdata),
        .dmi_resp_valid(dmi_resp_valid), .dmi_resp_rdata(dmi_resp_rdata), .dmi_resp_err(dmi_resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1);
    end

    // DMI slave: delayed ready, optional held response.
    initial begin
        int d;
        dmi_req_ready  = 1'b0;
        dmi_resp_valid = 1'b0;
        dmi_resp_rdata = 32'd0;
        dmi_resp_err   = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (dmi_req_valid) begin
                d = ready_dly;
                while ((d > 0 || ready_block) && dmi_req_valid) begin
                    @(posedge clk); #1;
                    if (d > 0) d--;
                end
                if (dmi_req_valid) begin
                    got_op = dmi_req_op; got_addr = dmi_req_addr; got_wdata = dmi_req_wdata;
                    dmi_req_ready = 1'b1;
                    @(posedge clk); #1;
                    dmi_req_ready = 1'b0;
                    req_cnt++;
                    checks++;
                    if (dmi_req_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL valid_drop: dmi_req_valid=%b after accept, expected 0", dmi_req_valid);
                    end
                    for (int k = 0; k < 5000 && resp_hold; k++) begin @(posedge clk); #1; end
                    checks++;
                    if (resp_hold) begin
                        errors++;
                        $display("FAIL resp_hold_timeout: hold still set=%b expected 0", resp_hold);
                    end
                    repeat (resp_dly) begin @(posedge clk); #1; end
                    dmi_resp_rdata = nxt_rdata;
                    dmi_resp_err   = nxt_err;
                    dmi_resp_valid = 1'b1;
                    @(posedge clk); #1;
                    dmi_resp_valid = 1'b0;
                    dmi_resp_rdata = $urandom;
                    dmi_resp_err   = 1'($urandom_range(0, 1));
                    resp_cnt++;
                end
            end
        end
    end

    task automatic tick(input logic m, input logic d);
        tms = m; tdi = d;
        @(posedge clk); #1;
    endtask

    task automatic shift_ir(input logic [4:0] code);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 5; i++) tick(i == 4, code[i]);
        tick(1, 0); tick(0, 0);
    endtask

    task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        tick(1, 0); tick(0, 0);
        if (n > 0) begin
            tick(0, 0);
            for (int i = 0; i < n; i++) begin
                dout[i] = tdo;
                tick(i == n - 1, din[i]);
            end
        end else begin
            tick(1, 0);
        end
        tick(1, 0); tick(0, 0);
    endtask

    task automatic poll(input string name);
        logic [63:0] o;
        shift_dr(34, 64'd0, o);
        checks++;
        if (o[1:0] !== m_status) begin
            errors++;
            $display("FAIL %s_status: got %0d expected %0d", name, o[1:0], m_status);
        end
        checks++;
        if (o[33:2] !== m_rdata) begin
            errors++;
            $display("FAIL %s_rdata: got %h expected %h", name, o[33:2], m_rdata);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                         input int n, output bit started);
        logic [63:0] din, dmask, dout;
        din   = {23'd0, data, addr, op};
        dmask = (64'd1 << n) - 64'd1;
        din   = din & dmask;
        shift_dr(n, din, dout);
        started = 0;
        if ((din[1:0] == 2'd1 || din[1:0] == 2'd2) && !m_busy) begin
            started  = 1;
            m_busy   = 1;
            m_status = 2'd3;
            e_req++;
            e_op = din[1:0]; e_addr = din[8:2]; e_wdata = din[40:9];
        end
    endtask

    task automatic complete(input string name);
        for (int k = 0; k < 300 && resp_cnt < e_req; k++) tick(0, 0);
        checks++;
        if (resp_cnt != e_req) begin
            errors++;
            $display("FAIL %s_timeout: responses %0d expected %0d", name, resp_cnt, e_req);
        end
        m_busy   = 0;
        m_status = nxt_err ? 2'd2 : 2'd0;
        if (e_op == 2'd1) m_rdata = nxt_rdata;
        checks++;
        if ({got_op, got_addr, got_wdata} !== {e_op, e_addr, e_wdata}) begin
            errors++;
            $display("FAIL %s_req: got op=%0d addr=%h wdata=%h expected op=%0d addr=%h wdata=%h",
                     name, got_op, got_addr, got_wdata, e_op, e_addr, e_wdata);
        end
    endtask

    task automatic check_btxcs(input string name);
        logic [63:0] o;
        logic [14:0] exp;
        exp = 15'h0001 | (15'(ABITS) << 4) | (15'(m_status) << 10) | (15'(1) << 12);
        shift_ir(5'h10);
        shift_dr(15, 64'h7FFF, o);
        checks++;
        if (o[14:0] !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, o[14:0], exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1, 0); tick(1, 0);
        checks++;
        if (tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo: got %b expected 0", tdo); end
        checks++;
        if (dmi_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dmi_req_valid); end
        checks++;
        if (select_val !== 32'd0) begin errors++; $display("FAIL reset_select: got %h expected 0", select_val); end
        checks++;
        if ({dmi_req_op, dmi_req_addr, dmi_req_wdata} !== 41'd0) begin
            errors++;
            $display("FAIL reset_req_fields: got %h expected 0", {dmi_req_op, dmi_req_addr, dmi_req_wdata});
        end
        rst = 1'b0;
        tick(0, 0);
    endtask

    task automatic test_idcode();
        logic [63:0] o;
        shift_dr(32, 64'(32'($urandom)), o);
        checks++;
        if (o[31:0] !== IDCODE) begin errors++; $display("FAIL idcode32: got %h expected %h", o[31:0], IDCODE); end
        shift_dr(40, 64'd0, o);
        checks++;
        if (o[39:0] !== 40'(IDCODE)) begin errors++; $display("FAIL idcode40: got %h expected %h", o[39:0], 40'(IDCODE)); end
    endtask

    task automatic test_btxcs();
        check_btxcs("btxcs_first");
        check_btxcs("btxcs_again");
    endtask

    task automatic test_select();
        logic [63:0] o;
        logic [31:0] v, w;
        shift_ir(5'h12);
        v = $urandom;
        shift_dr(32, {32'd0, v}, o);
        checks++;
        if (select_val !== v) begin errors++; $display("FAIL select_full: got %h expected %h", select_val, v); end
        w = $urandom;
        shift_dr(8, {56'd0, w[7:0]}, o);
        checks++;
        if (o[7:0] !== v[7:0]) begin errors++; $display("FAIL select_capture: got %h expected %h", o[7:0], v[7:0]); end
        checks++;
        if (select_val !== {24'd0, w[7:0]}) begin
            errors++; $display("FAIL select_short: got %h expected %h", select_val, {24'd0, w[7:0]});
        end
        shift_dr(32, 64'd0, o);
        checks++;
        if (o[31:0] !== {24'd0, w[7:0]}) begin
            errors++; $display("FAIL select_readback: got %h expected %h", o[31:0], {24'd0, w[7:0]});
        end
    endtask

    task automatic test_bypass();
        logic [63:0] o;
        logic [4:0]  codes [3] = '{5'h1F, 5'h05, 5'h00};
        for (int c = 0; c < 3; c++) begin
            shift_ir(codes[c]);
            shift_dr(16, 64'($urandom), o);
            checks++;
            if (o[15:0] !== 16'd0) begin
                errors++; $display("FAIL bypass_%0h: got %h expected 0", codes[c], o[15:0]);
            end
        end
    endtask

    task automatic test_btx_write();
        bit st;
        shift_ir(5'h11);
        poll("btx_reset");
        ready_dly = 2; resp_dly = 1; resp_hold = 1; nxt_err = 0; nxt_rdata = $urandom;
        issue(2'd2, 7'h10, 32'h1, 41, st);
        checks++;
        if (dmi_req_valid !== 1'b1) begin errors++; $display("FAIL write_valid_rise: got %b expected 1", dmi_req_valid); end
        poll("write_busy");
        resp_hold = 0;
        complete("write");
        poll("write_done");
    endtask

    task automatic test_btx_read();
        bit st;
        ready_dly = 0; resp_dly = 0; resp_hold = 1; nxt_err = 0; nxt_rdata = 32'hDEAD_BEEF;
        issue(2'd1, 7'h11, 32'd0, 9, st);
        poll("read_busy");
        resp_hold = 0;
        complete("read");
        poll("read_done");
    endtask

    task automatic test_back_to_back();
        bit st;
        ready_dly = 1; resp_dly = 2; resp_hold = 1; nxt_err = 0; nxt_rdata = $urandom;
        issue(2'd1, 7'h22, 32'd0, 9, st);
        issue(2'd1, 7'h33, 32'd0, 9, st);
        poll("b2b_busy");
        resp_hold = 0;
        complete("b2b");
        repeat (10) tick(0, 0);
        checks++;
        if (req_cnt != e_req) begin errors++; $display("FAIL b2b_count: got %0d requests expected %0d", req_cnt, e_req); end
        poll("b2b_done");
    endtask

    task automatic test_error_and_empty();
        bit st;
        ready_dly = 0; resp_dly = 3; resp_hold = 0; nxt_err = 1; nxt_rdata = $urandom;
        issue(2'd2, 7'h03, 32'($urandom), 41, st);
        complete("err");
        poll("err_status");
        check_btxcs("btxcs_err");
        shift_ir(5'h11);
        issue(2'd0, 7'd0, 32'd0, 0, st);
        repeat (8) tick(0, 0);
        checks++;
        if (req_cnt != e_req) begin errors++; $display("FAIL empty_update: got %0d requests expected %0d", req_cnt, e_req); end
        checks++;
        if (dmi_req_valid !== 1'b0) begin errors++; $display("FAIL empty_valid: got %b expected 0", dmi_req_valid); end
        poll("empty_status");
        nxt_err = 0;
    endtask

    task automatic test_random();
        bit          st;
        logic [1:0]  op;
        int          n;
        for (int it = 0; it < 12; it++) begin
            op        = 2'($urandom_range(0, 3));
            n         = $urandom_range(0, 1) ? 41 : 9;
            nxt_err   = ($urandom_range(0, 3) == 0);
            nxt_rdata = $urandom;
            ready_dly = $urandom_range(0, 3);
            resp_dly  = $urandom_range(0, 3);
            resp_hold = 1;
            issue(op, 7'($urandom), 32'($urandom), n, st);
            poll("rnd_pending");
            resp_hold = 0;
            if (st) begin
                complete("rnd");
            end else begin
                repeat (6) tick(0, 0);
                checks++;
                if (req_cnt != e_req) begin
                    errors++; $display("FAIL rnd_noreq: got %0d requests expected %0d", req_cnt, e_req);
                end
            end
            poll("rnd_done");
        end
        nxt_err = 0;
    endtask

    task automatic test_rst_pending();
        bit st;
        logic [63:0] o;
        ready_block = 1; ready_dly = 0; resp_dly = 0;
        issue(2'd1, 7'h05, 32'd0, 9, st);
        checks++;
        if (dmi_req_valid !== 1'b1) begin errors++; $display("FAIL rstp_valid: got %b expected 1", dmi_req_valid); end
        rst = 1'b1;
        #1;
        checks++;
        if (dmi_req_valid !== 1'b0) begin errors++; $display("FAIL rstp_drop: got %b expected 0", dmi_req_valid); end
        tick(1, 0); tick(1, 0);
        rst = 1'b0; ready_block = 0;
        m_status = 2'd0; m_rdata = 32'd0; m_busy = 0; e_req = e_req - 1;
        tick(0, 0);
        shift_dr(32, 64'd0, o);
        checks++;
        if (o[31:0] !== IDCODE) begin errors++; $display("FAIL rstp_ir: got %h expected %h", o[31:0], IDCODE); end
        shift_ir(5'h11);
        poll("rstp_btx");
        checks++;
        if (req_cnt != e_req) begin errors++; $display("FAIL rstp_count: got %0d requests expected %0d", req_cnt, e_req); end
    endtask

    task automatic test_tlr();
        logic [63:0] o;
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        tick(0, 1); tick(0, 0);
        repeat (5) tick(1, 0);
        tick(0, 0);
        shift_dr(32, 64'd0, o);
        checks++;
        if (o[31:0] !== IDCODE) begin errors++; $display("FAIL tlr_ir: got %h expected %h", o[31:0], IDCODE); end
    endtask

    initial begin
        rst = 1'b1; tms = 1'b1; tdi = 1'b0;
        test_reset();
        test_idcode();
        test_btxcs();
        test_select();
        test_bypass();
        test_btx_write();
        test_btx_read();
        test_back_to_back();
        test_error_and_empty();
        test_random();
        test_rst_pending();
        test_tlr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
